// File: rtl/vga_plot_sink_if.sv
// Plot bus from a drawing FSM plus the raster pixel stream returned by vga_plot_sink.
// The master side drives plots and accepts pixels; the slave side is the framebuffer.
interface vga_plot_sink_if;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       pix_valid;
    logic       pix_ready;
    logic [2:0] pix_colour;
    logic       pix_sof;
    logic       pix_eol;
    logic       pix_eof;

    modport master (
        output vga_x, vga_y, vga_colour, vga_plot, pix_ready,
        input  pix_valid, pix_colour, pix_sof, pix_eol, pix_eof
    );

    modport slave (
        input  vga_x, vga_y, vga_colour, vga_plot, pix_ready,
        output pix_valid, pix_colour, pix_sof, pix_eol, pix_eof
    );
endinterface

// File: rtl/vga_plot_sink.sv
// Framebuffer sink for the VGA plot interface: captures plotted pixels, can clear
// the buffer, and replays it as a raster-ordered valid/ready stream with sof/eol/eof.
module vga_plot_sink #(
    parameter int         WIDTH        = 160,
    parameter int         HEIGHT       = 120,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000,
    parameter int         CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    vga_plot_sink_if.slave   bus,
    input  logic             clr,
    input  logic             strt,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] plot_count,
    output logic [CNT_W-1:0] oob_count
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int AW   = 15;

    typedef enum logic [1:0] {IDLE, CLEAR, SCAN} state_t;
    state_t state, state_nxt;

    logic [2:0]    mem [NPIX];
    logic [AW-1:0] clr_addr, plot_addr, rd_addr, wr_addr;
    logic [7:0]    rd_x;
    logic [6:0]    rd_y;
    logic [2:0]    wr_data, s1_colour, s2_colour;
    logic          issue_pending;
    logic          s1_valid, s1_sof, s1_eol, s1_eof;
    logic          s2_valid, s2_sof, s2_eol, s2_eof;
    logic          plot_in_range, plot_ok, plot_drop, clr_last;
    logic          rd_last_x, rd_last_y, out_adv, rd_en, wr_en, eof_xfer;

    assign plot_in_range = (32'(bus.vga_x) < WIDTH) && (32'(bus.vga_y) < HEIGHT);
    assign plot_addr     = AW'(32'(bus.vga_y) * WIDTH + 32'(bus.vga_x));
    assign plot_ok       = bus.vga_plot && plot_in_range && (state != CLEAR);
    assign plot_drop     = bus.vga_plot && !plot_ok;
    assign clr_last      = (clr_addr == AW'(NPIX - 1));

    // A clear owns the single write port; plots arriving meanwhile are dropped.
    assign wr_en   = (state == CLEAR) || plot_ok;
    assign wr_addr = (state == CLEAR) ? clr_addr : plot_addr;
    assign wr_data = (state == CLEAR) ? CLEAR_COLOUR : bus.vga_colour;

    assign rd_last_x = (rd_x == 8'(WIDTH - 1));
    assign rd_last_y = (rd_y == 7'(HEIGHT - 1));
    assign rd_addr   = AW'(32'(rd_y) * WIDTH + 32'(rd_x));

    // Two-stage read pipeline (RAM register s1, output register s2); each stage
    // refills whenever the stage after it is empty or draining.
    assign out_adv  = !s2_valid || bus.pix_ready;
    assign rd_en    = (state == SCAN) && issue_pending && (!s1_valid || out_adv);
    assign eof_xfer = s2_valid && s2_eof && bus.pix_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: assign a default first so no path through the case can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr) state_nxt = CLEAR;
                     else if (strt) state_nxt = SCAN;
            CLEAR:   if (clr_last) state_nxt = IDLE;
            SCAN:    if (eof_xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // NOTE: the framebuffer has no reset so it maps onto block RAM; a read in the
    // same cycle as a write to that address returns the old contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) s1_colour <= mem[rd_addr];
    end

    // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_addr      <= '0;
            rd_x          <= '0;
            rd_y          <= '0;
            issue_pending <= 1'b0;
            s1_valid      <= 1'b0;
            s1_sof        <= 1'b0;
            s1_eol        <= 1'b0;
            s1_eof        <= 1'b0;
            s2_valid      <= 1'b0;
            s2_sof        <= 1'b0;
            s2_eol        <= 1'b0;
            s2_eof        <= 1'b0;
            s2_colour     <= '0;
            done          <= 1'b0;
            plot_count    <= '0;
            oob_count     <= '0;
        end else begin
            done <= ((state == CLEAR) && clr_last) || eof_xfer;

            if (state == CLEAR) clr_addr <= clr_last ? '0 : clr_addr + AW'(1);
            if ((state == IDLE) && (state_nxt == SCAN)) issue_pending <= 1'b1;

            if (rd_en) begin
                s1_valid <= 1'b1;
                s1_sof   <= (rd_x == '0) && (rd_y == '0);
                s1_eol   <= rd_last_x;
                s1_eof   <= rd_last_x && rd_last_y;
                if (rd_last_x) begin
                    rd_x <= '0;
                    if (rd_last_y) begin
                        rd_y          <= '0;
                        issue_pending <= 1'b0;
                    end else begin
                        rd_y <= rd_y + 7'd1;
                    end
                end else begin
                    rd_x <= rd_x + 8'd1;
                end
            end else if (out_adv) begin
                s1_valid <= 1'b0;
            end

            // Flags are gated with valid so they never linger once the stream drains.
            if (out_adv) begin
                s2_valid  <= s1_valid;
                s2_colour <= s1_colour;
                s2_sof    <= s1_valid && s1_sof;
                s2_eol    <= s1_valid && s1_eol;
                s2_eof    <= s1_valid && s1_eof;
            end

            if (plot_ok && (plot_count != '1))  plot_count <= plot_count + CNT_W'(1);
            if (plot_drop && (oob_count != '1)) oob_count  <= oob_count + CNT_W'(1);
        end
    end

    assign bus.pix_valid  = s2_valid;
    assign bus.pix_colour = s2_colour;
    assign bus.pix_sof    = s2_sof;
    assign bus.pix_eol    = s2_eol;
    assign bus.pix_eof    = s2_eof;

endmodule

// File: tb/tb_vga_plot_sink.sv
// Directed bench for vga_plot_sink: reset, aborted and full scans, clear priority,
// in-range and out-of-range plots, and a back-pressured scan against a pixel model.
module tb_vga_plot_sink;

    localparam int WIDTH  = 160;
    localparam int HEIGHT = 120;
    localparam int NPIX   = WIDTH * HEIGHT;

    logic        clk = 1'b0;
    logic        rst, clr, strt, busy, done;
    logic [15:0] plot_count, oob_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0] model [NPIX];
    int got_n, flag_err, eol_n, stall_err, data_err, lat, first_bad, scan_cycles;
    bit done_after, busy_after, valid_after, done_twice;

    vga_plot_sink_if bus ();

    vga_plot_sink #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .CLEAR_COLOUR(3'b000), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .clr(clr), .strt(strt),
        .busy(busy), .done(done), .plot_count(plot_count), .oob_count(oob_count)
    );

    always #5 clk = ~clk;

    task automatic do_plot(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        bus.vga_x = x; bus.vga_y = y; bus.vga_colour = c; bus.vga_plot = 1'b1;
        @(posedge clk); #1;
        bus.vga_plot = 1'b0;
    endtask

    // Starts a scan and consumes up to limit pixels; optional plot+clr pulse at iteration plot_at.
    task automatic run_scan(input bit rnd, input int limit, input bit chk_data, input int plot_at);
        int cyc;
        bit prev_stall, ready;
        logic [6:0] cur, snap;
        got_n = 0; flag_err = 0; eol_n = 0; stall_err = 0; data_err = 0;
        lat = -1; first_bad = -1; prev_stall = 1'b0; snap = '0; cyc = 0;
        bus.pix_ready = 1'b0;
        strt = 1'b1;
        while (got_n < limit && cyc < 4 * NPIX) begin
            @(posedge clk); #1;
            cyc++;
            strt = 1'b0;
            bus.vga_plot = (plot_at != 0) && (cyc == plot_at);
            clr          = (plot_at != 0) && (cyc == plot_at);
            cur = {bus.pix_valid, bus.pix_colour, bus.pix_sof, bus.pix_eol, bus.pix_eof};
            if (prev_stall && cur !== snap) stall_err++;
            if (bus.pix_valid && lat < 0) lat = cyc - 1;
            ready = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
            bus.pix_ready = ready;
            if (bus.pix_valid && ready) begin
                if (chk_data && bus.pix_colour !== model[got_n]) begin
                    data_err++;
                    if (first_bad < 0) first_bad = got_n;
                end
                if (bus.pix_sof !== (got_n == 0)) flag_err++;
                if (bus.pix_eol !== (got_n % WIDTH == WIDTH - 1)) flag_err++;
                if (bus.pix_eof !== (got_n == NPIX - 1)) flag_err++;
                if (bus.pix_eol) eol_n++;
                got_n++;
            end
            prev_stall = bus.pix_valid && !ready;
            snap = cur;
        end
        scan_cycles = cyc - lat;
        clr = 1'b0;
        bus.vga_plot = 1'b0;
        if (limit == NPIX) begin
            @(posedge clk); #1;
            done_after = done; busy_after = busy; valid_after = bus.pix_valid;
            @(posedge clk); #1;
            done_twice = done;
            bus.pix_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; strt = 1'b0;
        bus.vga_x = '0; bus.vga_y = '0; bus.vga_colour = '0; bus.vga_plot = 1'b0;
        bus.pix_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, bus.pix_valid, bus.pix_sof, bus.pix_eol, bus.pix_eof, bus.pix_colour} !== 9'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b expected 000000000",
                     {busy, done, bus.pix_valid, bus.pix_sof, bus.pix_eol, bus.pix_eof, bus.pix_colour});
        end
        n_cmp++;
        if ({plot_count, oob_count} !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_counters: got plot=%0d oob=%0d expected 0/0", plot_count, oob_count);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, bus.pix_valid} !== 3'b000) begin
            n_bad++;
            $display("FAIL idle_after_reset: got busy/done/valid=%b expected 000", {busy, done, bus.pix_valid});
        end
    endtask

    task automatic test_scan_reset();
        run_scan(1'b0, 5000, 1'b0, 0);
        n_cmp++;
        if (got_n !== 5000) begin
            n_bad++;
            $display("FAIL abort_pixels: got %0d expected 5000", got_n);
        end
        n_cmp++;
        if ({bus.pix_valid, busy} !== 2'b11) begin
            n_bad++;
            $display("FAIL pre_reset_active: got valid/busy=%b expected 11", {bus.pix_valid, busy});
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.pix_valid, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_mid_scan: got valid/busy=%b expected 00", {bus.pix_valid, busy});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.pix_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_full_scan();
        run_scan(1'b0, NPIX, 1'b0, 0);
        n_cmp++;
        if (got_n !== NPIX) begin
            n_bad++;
            $display("FAIL full_scan_pixels: got %0d expected %0d", got_n, NPIX);
        end
        n_cmp++;
        if (lat !== 2) begin
            n_bad++;
            $display("FAIL first_valid_latency: got %0d expected 2", lat);
        end
        n_cmp++;
        if (scan_cycles !== NPIX) begin
            n_bad++;
            $display("FAIL no_bubbles: got %0d cycles expected %0d", scan_cycles, NPIX);
        end
        n_cmp++;
        if (flag_err !== 0 || eol_n !== HEIGHT) begin
            n_bad++;
            $display("FAIL scan_flags: got flag_err=%0d eol=%0d expected 0/%0d", flag_err, eol_n, HEIGHT);
        end
        n_cmp++;
        if ({done_after, busy_after, valid_after, done_twice} !== 4'b1000) begin
            n_bad++;
            $display("FAIL scan_end: got done/busy/valid/done_next=%b expected 1000",
                     {done_after, busy_after, valid_after, done_twice});
        end
    endtask

    task automatic test_oob();
        do_plot(8'd160, 7'd0, 3'b111);
        do_plot(8'd0, 7'd120, 3'b111);
        n_cmp++;
        if (oob_count !== 16'd2 || plot_count !== 16'd0) begin
            n_bad++;
            $display("FAIL oob_counts: got oob=%0d plot=%0d expected 2/0", oob_count, plot_count);
        end
    endtask

    task automatic test_clear_priority();
        int busy_n, cyc;
        bit saw_valid, got_done, busy_at_done;
        busy_n = 0; cyc = 0; saw_valid = 1'b0; got_done = 1'b0; busy_at_done = 1'b1;
        bus.vga_x = 8'd3; bus.vga_y = 7'd3; bus.vga_colour = 3'b111;
        clr = 1'b1; strt = 1'b1;
        while (!got_done && cyc < NPIX + 100) begin
            @(posedge clk); #1;
            cyc++;
            clr = 1'b0; strt = 1'b0;
            bus.vga_plot = (cyc == 10);
            if (bus.pix_valid) saw_valid = 1'b1;
            if (done) begin
                got_done = 1'b1;
                busy_at_done = busy;
            end else if (busy) begin
                busy_n++;
            end
        end
        bus.vga_plot = 1'b0;
        for (int i = 0; i < NPIX; i++) model[i] = 3'b000;
        n_cmp++;
        if (busy_n !== NPIX || !got_done) begin
            n_bad++;
            $display("FAIL clear_length: got %0d busy cycles done=%0b expected %0d/1", busy_n, got_done, NPIX);
        end
        n_cmp++;
        if ({saw_valid, busy_at_done} !== 2'b00) begin
            n_bad++;
            $display("FAIL clear_no_stream: got valid_seen/busy_at_done=%b expected 00", {saw_valid, busy_at_done});
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_done_pulse: got done=%0b expected 0", done);
        end
        n_cmp++;
        if (oob_count !== 16'd3 || plot_count !== 16'd0) begin
            n_bad++;
            $display("FAIL plot_during_clear: got oob=%0d plot=%0d expected 3/0", oob_count, plot_count);
        end
    endtask

    task automatic test_plot();
        do_plot(8'd5, 7'd7, 3'b101);
        do_plot(8'd159, 7'd119, 3'b011);
        do_plot(8'd160, 7'd0, 3'b111);
        model[1125]  = 3'b101;
        model[19199] = 3'b011;
        n_cmp++;
        if (plot_count !== 16'd2 || oob_count !== 16'd4) begin
            n_bad++;
            $display("FAIL plot_counts: got plot=%0d oob=%0d expected 2/4", plot_count, oob_count);
        end
    endtask

    task automatic test_back_pressure();
        bus.vga_x = 8'd100; bus.vga_y = 7'd100; bus.vga_colour = 3'b110;
        model[16100] = 3'b110;
        run_scan(1'b1, NPIX, 1'b1, 1);
        n_cmp++;
        if (got_n !== NPIX) begin
            n_bad++;
            $display("FAIL bp_pixels: got %0d expected %0d", got_n, NPIX);
        end
        n_cmp++;
        if (data_err !== 0) begin
            n_bad++;
            $display("FAIL bp_data: got %0d wrong pixels (first at %0d) expected 0", data_err, first_bad);
        end
        n_cmp++;
        if (stall_err !== 0) begin
            n_bad++;
            $display("FAIL bp_stall_stable: got %0d changes while stalled expected 0", stall_err);
        end
        n_cmp++;
        if (flag_err !== 0 || eol_n !== HEIGHT || lat !== 2) begin
            n_bad++;
            $display("FAIL bp_flags: got flag_err=%0d eol=%0d lat=%0d expected 0/%0d/2", flag_err, eol_n, lat, HEIGHT);
        end
        n_cmp++;
        if ({done_after, busy_after, valid_after, done_twice} !== 4'b1000) begin
            n_bad++;
            $display("FAIL bp_scan_end: got done/busy/valid/done_next=%b expected 1000",
                     {done_after, busy_after, valid_after, done_twice});
        end
        n_cmp++;
        if (plot_count !== 16'd3 || oob_count !== 16'd4) begin
            n_bad++;
            $display("FAIL bp_counts: got plot=%0d oob=%0d expected 3/4", plot_count, oob_count);
        end
    endtask

    initial begin
        test_reset();
        test_scan_reset();
        test_full_scan();
        test_oob();
        test_clear_priority();
        test_plot();
        test_back_pressure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
